pipelined_barrel_shifter: RTL and testbench

//   Parametrised, pipelined multi-mode shifter. Supports logical right/left,

---
 rtl/pipelined_barrel_shifter_if.sv | 35 +++
 rtl/pipelined_barrel_shifter.sv | 110 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Stream bundle between an operand source and a result consumer for the
// pipelined barrel shifter.
//   in_valid/in_ready   input beat handshake
//   in_data             operand, WIDTH bits
//   in_shamt            shift amount, $clog2(WIDTH)+1 bits (MSB = out of range)
//   in_mode             00 LSR, 01 LSL, 10 ASR, 11 ROR
//   out_valid/out_ready result handshake
//   out_data            shifted result
//   out_zero            out_data == 0, qualified by out_valid
// master: operand source / result consumer side. slave: shifter side.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 8
) ();
  localparam int SHAMT_W = $clog2(WIDTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (LSR, LSL, ASR, ROR) with valid/ready
// handshakes on both sides. $clog2(WIDTH) register stages; stage k shifts by
// 2^k when shamt bit k is set. Whole pipeline freezes while the output is
// stalled; bubbles are not collapsed.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, discards in-flight beats
//   bus  pipelined_barrel_shifter_if.slave (operand in, result out)
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int LOG2W   = $clog2(WIDTH);
  localparam int SHAMT_W = LOG2W + 1;
  localparam int LAST    = LOG2W - 1;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // data/valid exist for every stage (the last one is the output register);
  // shamt/mode/oor only need to travel as far as the final stage's input.
  logic [LOG2W-1:0][WIDTH-1:0]  data_q;
  logic [LOG2W-1:0]             valid_q;
  logic [LAST-1:0][SHAMT_W-1:0] shamt_q;
  logic [LAST-1:0][1:0]         mode_q;
  logic [LAST-1:0]              oor_q;
  logic                         zero_q;

  logic [LOG2W-1:0][WIDTH-1:0]   d_in;
  logic [LOG2W-1:0][WIDTH-1:0]   d_nxt;
  logic [LOG2W-1:0][SHAMT_W-1:0] s_in;
  logic [LOG2W-1:0][1:0]         m_in;
  logic [LOG2W-1:0]              v_in;
  logic [LOG2W-1:0]              o_in;
  logic [WIDTH-1:0]              fin;
  logic                          stall;

  assign stall         = valid_q[LAST] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_data  = data_q[LAST];
  assign bus.out_zero  = zero_q;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       mode,
                                                input int               amt);
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_LSR: r = d >> amt;
      MODE_LSL: r = d << amt;
      MODE_ASR: r = $signed(d) >>> amt;
      default:  r = (d >> amt) | (d << (WIDTH - amt));
    endcase
    return r;
  endfunction

  always_comb begin
    d_in[0] = bus.in_data;
    s_in[0] = bus.in_shamt;
    m_in[0] = bus.in_mode;
    v_in[0] = bus.in_valid;
    o_in[0] = bus.in_shamt[LOG2W];
    for (int k = 1; k < LOG2W; k++) begin
      d_in[k] = data_q[k-1];
      s_in[k] = shamt_q[k-1];
      m_in[k] = mode_q[k-1];
      v_in[k] = valid_q[k-1];
      o_in[k] = oor_q[k-1];
    end
    for (int k = 0; k < LOG2W; k++) begin
      d_nxt[k] = s_in[k][k] ? shift_by(d_in[k], m_in[k], 1 << k) : d_in[k];
    end
    // Out-of-range override. ASR stages never change the MSB, so the final
    // stage input still carries the operand's sign bit. ROR needs nothing:
    // the ignored top shamt bit already gives amount mod WIDTH.
    fin = d_nxt[LAST];
    if (o_in[LAST]) begin
      case (m_in[LAST])
        MODE_LSR, MODE_LSL: fin = '0;
        MODE_ASR:           fin = {WIDTH{d_in[LAST][WIDTH-1]}};
        default:            fin = d_nxt[LAST];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      oor_q   <= '0;
      zero_q  <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < LAST; k++) begin
        data_q[k]  <= d_nxt[k];
        shamt_q[k] <= s_in[k];
        mode_q[k]  <= m_in[k];
        oor_q[k]   <= o_in[k];
      end
      data_q[LAST] <= fin;
      valid_q      <= v_in;
      zero_q       <= v_in[LAST] & (fin == '0);
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and random checks for pipelined_barrel_shifter (WIDTH=8).
module tb_pipelined_barrel_shifter;
  localparam int WIDTH = 8;
  localparam logic [1:0] LSR = 2'b00;
  localparam logic [1:0] LSL = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();
  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] data;
    int         stamp;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         ncyc = 0;
  int         cyc = 0;
  int         stall_lo = -1;
  int         stall_hi = -1;
  int         stall_cnt = 0;
  logic [7:0] exp_in;
  bit         chk_lat;
  bit         rand_ready;
  bit         prev_stall;
  logic [7:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-by-bit reference: each result bit picks its source bit directly.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] s,
                                           input logic [1:0] m);
    logic [7:0] r;
    int sh;
    int src;
    sh = int'(s);
    for (int i = 0; i < 8; i++) begin
      case (m)
        LSR: begin src = i + sh; r[i] = (src < 8) ? d[src] : 1'b0; end
        LSL: begin src = i - sh; r[i] = (src >= 0) ? d[src] : 1'b0; end
        ASR: begin src = i + sh; r[i] = (src < 8) ? d[src] : d[7]; end
        default: begin src = (i + (sh % 8)) % 8; r[i] = d[src]; end
      endcase
    end
    return r;
  endfunction

  // out_ready driver: fixed stall window or random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      else            bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  // Monitor / scoreboard, sampled on the falling edge
  initial begin
    exp_t e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
          check_eq("hold_data", 32'(bus.out_data), 32'(prev_data));
        end
        check_eq("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
        if (bus.in_valid && bus.in_ready) sb.push_back('{exp_in, ncyc});
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check_eq("out_data", 32'(bus.out_data), 32'(e.data));
            check_eq("out_zero", 32'(bus.out_zero), 32'(e.data == 8'h00));
            if (chk_lat) check_eq("latency", 32'(ncyc - e.stamp), 32'd3);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        if (prev_stall) stall_cnt++;
        prev_data = bus.out_data;
      end
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] s, input logic [1:0] m,
                      input logic [7:0] e);
    int g;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    exp_in       = e;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check_eq("accept_timeout", 32'(g), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    bus.in_valid = 1'b0;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    idle(2);
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] s;
    logic [1:0] m;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_mode  = '0;
    exp_in       = '0;
    chk_lat      = 1'b1;
    rand_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_out_zero", 32'(bus.out_zero), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: LSR back-to-back, including out-of-range amount
    send(8'b0011_0011, 4'd2,  LSR, 8'b0000_1100);
    send(8'b1111_0000, 4'd4,  LSR, 8'b0000_1111);
    send(8'b0011_1100, 4'd10, LSR, 8'b0000_0000);
    drain();

    // 2: ASR, in range and out of range for both signs
    send(8'b1001_0000, 4'd3,  ASR, 8'b1111_0010);
    send(8'b1001_0000, 4'd12, ASR, 8'b1111_1111);
    send(8'b0111_0000, 4'd12, ASR, 8'b0000_0000);
    drain();

    // 3: LSL / ROR, ROR mod WIDTH and zero amount
    send(8'b0000_0011, 4'd7, LSL, 8'b1000_0000);
    send(8'b1000_0001, 4'd9, ROR, 8'b1100_0000);
    send(8'b1011_0001, 4'd0, ROR, 8'b1011_0001);
    send(8'b1100_1010, 4'd0, ASR, 8'b1100_1010);
    drain();

    // 4: backpressure window while 5 beats are offered every cycle
    chk_lat   = 1'b0;
    stall_cnt = 0;
    stall_lo  = cyc + 4;
    stall_hi  = cyc + 8;
    send(8'hFF, 4'd1, LSR, 8'h7F);
    send(8'h01, 4'd3, LSL, 8'h08);
    send(8'h80, 4'd1, ASR, 8'hC0);
    send(8'h01, 4'd1, ROR, 8'h80);
    send(8'hA5, 4'd0, LSL, 8'hA5);
    drain();
    check_eq("stall_seen", 32'(stall_cnt > 2), 32'd1);
    stall_lo = -1;
    stall_hi = -1;

    // 5: reset while two beats are in flight
    chk_lat = 1'b1;
    send(8'h55, 4'd1, LSR, 8'h2A);
    send(8'hAA, 4'd1, LSR, 8'h55);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    idle(5);
    send(8'h0F, 4'd4, ROR, 8'hF0);
    drain();

    // 6: random traffic with random backpressure
    chk_lat    = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      d = 8'($urandom);
      s = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      send(d, s, m, ref_shift(d, s, m));
    end
    drain();
    rand_ready = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end
endmodule
